// File: rtl/des_f_pipe.sv
// des_f_pipe: three-stage pipelined DES round function f(R, K).
// Stage 1 registers E(R) ^ K. Stage 2 registers the eight S-box outputs.
// Stage 3 registers P(S). Valid/ready flow control is used throughout.
// All stages advance together whenever the output is free or being consumed.

// Shared 64-entry S-box lookup. The table is a packed parameter with entry 0
// in the top nibble. The index is row*16 + column, where row = {in[5], in[0]}
// and column = in[4:1]. The bit offset of an entry is 255 - 4*idx, which is
// written as {~idx, 2'b11} so that it stays an exact 8-bit index.
module des_sbox_lut #(
  parameter logic [255:0] TBL = '0
) (
  input  logic [5:0] in,
  output logic [3:0] out
);
  logic [5:0] idx;
  assign idx = {in[5], in[0], in[4:1]};
  assign out = TBL[{~idx, 2'b11} -: 4];
endmodule

module S_Box_1 (input logic [5:0] in, output logic [3:0] out);
  des_sbox_lut #(.TBL(256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D))
    u_lut (.in(in), .out(out));
endmodule

module S_Box_2 (input logic [5:0] in, output logic [3:0] out);
  des_sbox_lut #(.TBL(256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9))
    u_lut (.in(in), .out(out));
endmodule

module S_Box_3 (input logic [5:0] in, output logic [3:0] out);
  des_sbox_lut #(.TBL(256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C))
    u_lut (.in(in), .out(out));
endmodule

module S_Box_4 (input logic [5:0] in, output logic [3:0] out);
  des_sbox_lut #(.TBL(256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E))
    u_lut (.in(in), .out(out));
endmodule

module S_Box_5 (input logic [5:0] in, output logic [3:0] out);
  des_sbox_lut #(.TBL(256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453))
    u_lut (.in(in), .out(out));
endmodule

module S_Box_6 (input logic [5:0] in, output logic [3:0] out);
  des_sbox_lut #(.TBL(256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D))
    u_lut (.in(in), .out(out));
endmodule

module S_Box_7 (input logic [5:0] in, output logic [3:0] out);
  des_sbox_lut #(.TBL(256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C))
    u_lut (.in(in), .out(out));
endmodule

module S_Box_8 (input logic [5:0] in, output logic [3:0] out);
  des_sbox_lut #(.TBL(256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B))
    u_lut (.in(in), .out(out));
endmodule

module des_f_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] r_in,
  input  logic [47:0] k_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] f_out
);
  logic        adv;
  logic [47:0] expR;
  logic [47:0] s1_x_d, s1_x_q;
  logic [31:0] s2_s_d, s2_s_q;
  logic [31:0] f_d, f_q;
  logic        v1_q, v2_q, ov_q;

  // The whole pipe moves as one; it stalls only when a held output is not taken.
  assign adv      = !ov_q || out_ready;
  assign in_ready = adv;

  // E expansion: group i takes DES bits 4i..4i+5, wrapping around bit 32/1.
  assign expR   = {r_in[0], r_in[31:27], r_in[28:23], r_in[24:19], r_in[20:15],
                   r_in[16:11], r_in[12:7], r_in[8:3], r_in[4:0], r_in[31]};
  assign s1_x_d = expR ^ k_in;

  S_Box_1 u_sb1 (.in(s1_x_q[47:42]), .out(s2_s_d[31:28]));
  S_Box_2 u_sb2 (.in(s1_x_q[41:36]), .out(s2_s_d[27:24]));
  S_Box_3 u_sb3 (.in(s1_x_q[35:30]), .out(s2_s_d[23:20]));
  S_Box_4 u_sb4 (.in(s1_x_q[29:24]), .out(s2_s_d[19:16]));
  S_Box_5 u_sb5 (.in(s1_x_q[23:18]), .out(s2_s_d[15:12]));
  S_Box_6 u_sb6 (.in(s1_x_q[17:12]), .out(s2_s_d[11:8]));
  S_Box_7 u_sb7 (.in(s1_x_q[11:6]),  .out(s2_s_d[7:4]));
  S_Box_8 u_sb8 (.in(s1_x_q[5:0]),   .out(s2_s_d[3:0]));

  // P permutation: output DES bit j takes S bit P[j], i.e. vector bit 32 - P[j].
  assign f_d = {s2_s_q[16], s2_s_q[25], s2_s_q[12], s2_s_q[11],
                s2_s_q[3],  s2_s_q[20], s2_s_q[4],  s2_s_q[15],
                s2_s_q[31], s2_s_q[17], s2_s_q[9],  s2_s_q[6],
                s2_s_q[27], s2_s_q[14], s2_s_q[1],  s2_s_q[22],
                s2_s_q[30], s2_s_q[24], s2_s_q[8],  s2_s_q[18],
                s2_s_q[0],  s2_s_q[5],  s2_s_q[29], s2_s_q[23],
                s2_s_q[13], s2_s_q[19], s2_s_q[2],  s2_s_q[26],
                s2_s_q[10], s2_s_q[21], s2_s_q[28], s2_s_q[7]};

  // Valid bits: flush drops everything in flight (and the incoming item); otherwise shift on adv.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      ov_q <= 1'b0;
    end else if (flush) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      ov_q <= 1'b0;
    end else if (adv) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      ov_q <= v2_q;
    end
  end

  // Data registers follow adv only; their contents under a cleared valid are don't-care.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_x_q <= '0;
      s2_s_q <= '0;
      f_q    <= '0;
    end else if (adv) begin
      s1_x_q <= s1_x_d;
      s2_s_q <= s2_s_d;
      f_q    <= f_d;
    end
  end

  assign out_valid = ov_q;
  assign f_out     = f_q;
endmodule

// File: tb/tb_des_f_pipe.sv
// tb_des_f_pipe: directed, table-driven check of the pipelined DES f function.
module tb_des_f_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] r_in;
  logic [47:0] k_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] f_out;

  int nVec  = 0;
  int nMiss = 0;

  typedef struct {
    logic [31:0] r;
    logic [47:0] k;
    logic [47:0] s1;
    logic [31:0] s2;
    logic [31:0] f;
  } vec_t;

  vec_t tbl[4];

  des_f_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .r_in(r_in), .k_in(k_in),
    .out_valid(out_valid), .out_ready(out_ready), .f_out(f_out)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  // Hard stop if something wedges the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic v, input logic [31:0] r, input logic [47:0] k);
    in_valid = v;
    r_in     = r;
    k_in     = k;
  endtask

  task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  logic [31:0] sbq[$];
  int pushed;

  initial begin
    tbl[0] = '{r: 32'hF0AAF0AA, k: 48'h1B02EFFC7072, s1: 48'h6117BA866527, s2: 32'h5C82B597, f: 32'h234AA9BB};
    tbl[1] = '{r: 32'h00000000, k: 48'h000000000000, s1: 48'h000000000000, s2: 32'hEFA72C4D, f: 32'hD8D8DBBC};
    tbl[2] = '{r: 32'h00000000, k: 48'hFFFFFFFFFFFF, s1: 48'hFFFFFFFFFFFF, s2: 32'hD9CE3DCB, f: 32'h38DBF9CB};
    tbl[3] = '{r: 32'hFFFFFFFF, k: 48'hFFFFFFFFFFFF, s1: 48'h000000000000, s2: 32'hEFA72C4D, f: 32'hD8D8DBBC};

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    applyStimulus(1'b0, '0, '0);

    // Reset state, checked before any clock edge and again while held.
    #3;
    checkOutput("rst_out_valid", 48'(out_valid), 48'd0);
    checkOutput("rst_f_out",     48'(f_out), 48'd0);
    checkOutput("rst_in_ready",  48'(in_ready), 48'd1);
    checkOutput("rst_s1_x",      dut.s1_x_q, 48'd0);
    checkOutput("rst_s2_s",      48'(dut.s2_s_q), 48'd0);
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready_held", 48'(in_ready), 48'd1);
    rst_n = 1'b1;

    // Single items from the table, each with full latency and one-cycle valid checks.
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      out_ready = 1'b1;
      applyStimulus(1'b1, tbl[v].r, tbl[v].k);
      @(negedge clk);
      applyStimulus(1'b0, '0, '0);
      checkOutput($sformatf("tbl%0d_s1_x", v), dut.s1_x_q, tbl[v].s1);
      @(negedge clk);
      checkOutput($sformatf("tbl%0d_s2_s", v), 48'(dut.s2_s_q), 48'(tbl[v].s2));
      checkOutput($sformatf("tbl%0d_early_valid", v), 48'(out_valid), 48'd0);
      @(negedge clk);
      checkOutput($sformatf("tbl%0d_valid", v), 48'(out_valid), 48'd1);
      checkOutput($sformatf("tbl%0d_f_out", v), 48'(f_out), 48'(tbl[v].f));
      @(negedge clk);
      checkOutput($sformatf("tbl%0d_valid_drop", v), 48'(out_valid), 48'd0);
    end

    // Back-to-back streaming of textbook / zero vectors.
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        checkOutput($sformatf("stream%0d_valid", c), 48'(out_valid), 48'd1);
        checkOutput($sformatf("stream%0d_f_out", c), 48'(f_out), 48'(tbl[(c - 3) % 2].f));
      end
      if (c < 8) applyStimulus(1'b1, tbl[c % 2].r, tbl[c % 2].k);
      else       applyStimulus(1'b0, '0, '0);
    end

    // Backpressure: a 5-cycle hold of out_ready in the middle of a stream, scoreboarded.
    pushed = 0;
    sbq.delete();
    for (int c = 0; c < 40 && (pushed < 12 || sbq.size() > 0); c++) begin
      @(negedge clk);
      out_ready = !(c >= 6 && c < 11);
      if (pushed < 12) applyStimulus(1'b1, tbl[pushed % 2].r, tbl[pushed % 2].k);
      else             applyStimulus(1'b0, '0, '0);
      #1;
      checkOutput($sformatf("bp%0d_in_ready", c), 48'(in_ready), 48'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) checkOutput($sformatf("bp%0d_spurious", c), 48'(out_valid), 48'd0);
        else checkOutput($sformatf("bp%0d_data", c), 48'(f_out), 48'(sbq.pop_front()));
      end else if (out_valid && sbq.size() > 0) begin
        checkOutput($sformatf("bp%0d_hold", c), 48'(f_out), 48'(sbq[0]));
      end
      if (in_valid && in_ready) begin
        sbq.push_back(tbl[pushed % 2].f);
        pushed++;
      end
    end
    checkOutput("bp_drained", 48'(sbq.size()), 48'd0);
    checkOutput("bp_pushed", 48'(pushed), 48'd12);
    out_ready = 1'b1;
    applyStimulus(1'b0, '0, '0);
    repeat (4) @(negedge clk);

    // Flush with three items in flight and a valid input in the flush cycle.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      applyStimulus(1'b1, tbl[0].r, tbl[0].k);
    end
    @(negedge clk);
    checkOutput("flush_pre_valid", 48'(out_valid), 48'd1);
    flush = 1'b1;
    applyStimulus(1'b1, tbl[1].r, tbl[1].k);
    #1;
    checkOutput("flush_in_ready", 48'(in_ready), 48'd1);
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_out_valid", 48'(out_valid), 48'd0);
    checkOutput("flush_v1", 48'(dut.v1_q), 48'd0);
    checkOutput("flush_v2", 48'(dut.v2_q), 48'd0);
    applyStimulus(1'b1, tbl[2].r, tbl[2].k);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      applyStimulus(1'b0, '0, '0);
      checkOutput($sformatf("postflush%0d_valid", j), 48'(out_valid), (j == 3) ? 48'd1 : 48'd0);
      if (j == 3) checkOutput("postflush_f_out", 48'(f_out), 48'(tbl[2].f));
    end

    // Asynchronous reset in the middle of a stream.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      applyStimulus(1'b1, tbl[c % 2].r, tbl[c % 2].k);
    end
    @(posedge clk);
    #2;
    applyStimulus(1'b0, '0, '0);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", 48'(out_valid), 48'd0);
    checkOutput("arst_f_out",     48'(f_out), 48'd0);
    checkOutput("arst_in_ready",  48'(in_ready), 48'd1);
    checkOutput("arst_v1",        48'(dut.v1_q), 48'd0);
    checkOutput("arst_v2",        48'(dut.v2_q), 48'd0);
    checkOutput("arst_s1_x",      dut.s1_x_q, 48'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("arst_rel_in_ready", 48'(in_ready), 48'd1);
    @(negedge clk);
    applyStimulus(1'b1, tbl[0].r, tbl[0].k);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      applyStimulus(1'b0, '0, '0);
      checkOutput($sformatf("postrst%0d_valid", j), 48'(out_valid), (j == 3) ? 48'd1 : 48'd0);
      if (j == 3) checkOutput("postrst_f_out", 48'(f_out), 48'(tbl[0].f));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end
endmodule
